// File: rtl/bias_relu.sv
// Per-channel bias add followed by ReLU and unsigned saturation.
// Two-stage valid/ready pipeline; a full stage 1 always moves into an empty stage 2.
module bias_relu #(
  parameter int unsigned I_BW    = 32,
  parameter int unsigned BIAS_BW = 32,
  parameter int unsigned O_BW    = 32,
  parameter int unsigned NUM_CH  = 8,
  parameter int unsigned CH_BW   = $clog2(NUM_CH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_CH*BIAS_BW-1:0] bias_i,
  input  logic [I_BW-1:0]           data_i,
  input  logic                      valid_i,
  input  logic                      last_i,
  output logic                      ready_o,
  output logic [O_BW-1:0]           data_o,
  output logic                      valid_o,
  output logic                      last_o,
  input  logic                      ready_i
);

  // One extra bit above the wider operand keeps the sum exact.
  localparam int unsigned SUM_BW = ((I_BW > BIAS_BW) ? I_BW : BIAS_BW) + 1;
  localparam int unsigned CMP_BW = (SUM_BW > O_BW + 1) ? SUM_BW : O_BW + 1;

  logic signed [SUM_BW-1:0]  sum1_q;
  logic signed [SUM_BW-1:0]  sum_c;
  logic                      last1_q;
  logic                      v1_q;
  logic [CH_BW-1:0]          ch_q;
  logic [BIAS_BW-1:0]        bias_sel_c;
  logic [O_BW-1:0]           relu_c;
  logic [CMP_BW-1:0]         sum_ext_c;
  logic                      s1_rdy_c;
  logic                      s2_rdy_c;
  logic                      accept_c;

  assign s2_rdy_c = !valid_o || ready_i;
  assign s1_rdy_c = !v1_q || s2_rdy_c;
  assign ready_o  = s1_rdy_c;
  assign accept_c = valid_i && s1_rdy_c;

  // Bias lane for the current channel.
  always_comb begin
    bias_sel_c = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_BW'(k)) bias_sel_c = bias_i[k*BIAS_BW +: BIAS_BW];
    end
  end

  assign sum_c = SUM_BW'($signed(data_i)) + SUM_BW'($signed(bias_sel_c));

  // ReLU and clamp to the unsigned output range.
  always_comb begin
    sum_ext_c = CMP_BW'($unsigned(sum1_q));
    relu_c    = O_BW'($unsigned(sum1_q));
    if (sum1_q[SUM_BW-1]) begin
      relu_c = '0;
    end else if (sum_ext_c > CMP_BW'({O_BW{1'b1}})) begin
      relu_c = '1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum1_q  <= '0;
      last1_q <= 1'b0;
      v1_q    <= 1'b0;
      ch_q    <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else begin
      if (s1_rdy_c) begin
        v1_q <= accept_c;
        if (accept_c) begin
          sum1_q  <= sum_c;
          last1_q <= last_i;
        end
      end
      // A frame end restarts the channel sequence.
      if (accept_c) begin
        if (last_i || (ch_q == CH_BW'(NUM_CH - 1))) ch_q <= '0;
        else                                       ch_q <= ch_q + CH_BW'(1);
      end
      if (s2_rdy_c) begin
        valid_o <= v1_q;
        if (v1_q) begin
          data_o <= relu_c;
          last_o <= last1_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_bias_relu.sv
// Directed bench for bias_relu: ordering, latency, ReLU, saturation, stall, last and reset.
module tb_bias_relu;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [255:0] bias;
  logic [31:0]  data_i;
  logic         valid_i;
  logic         last_i;
  logic         ready_i;
  logic         ready_o;
  logic [31:0]  data_o;
  logic         valid_o;
  logic         last_o;
  logic         ready16;
  logic [15:0]  data16;
  logic         valid16;
  logic         last16;

  int total = 0;
  int bad   = 0;

  logic [31:0] got_d[$];
  logic        got_l[$];
  logic [31:0] exp_d[$];
  logic        exp_l[$];

  always #5 clk = ~clk;

  bias_relu dut (
    .clk_i(clk), .rst_i(rst_i), .bias_i(bias), .data_i(data_i), .valid_i(valid_i),
    .last_i(last_i), .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o),
    .last_o(last_o), .ready_i(ready_i)
  );

  bias_relu #(.O_BW(16)) dut16 (
    .clk_i(clk), .rst_i(rst_i), .bias_i(bias), .data_i(data_i), .valid_i(valid_i),
    .last_i(last_i), .ready_o(ready16), .data_o(data16), .valid_o(valid16),
    .last_o(last16), .ready_i(ready_i)
  );

  // Record every delivered beat of the 32-bit instance.
  always @(posedge clk) begin
    if (valid_o && ready_i) begin
      got_d.push_back(data_o);
      got_l.push_back(last_o);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; valid_i = 1'b0; last_i = 1'b0; data_i = '0;
    step();
    step();
    rst_i = 1'b0;
    got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
  endtask

  task automatic bias_lin();
    for (int k = 0; k < 8; k++) bias[k*32 +: 32] = 32'(10 * k);
  endtask

  // Single beat with last set; checks both widths two edges after acceptance.
  task automatic one_beat(input string tag, input logic [31:0] d,
                          input logic [31:0] e32, input logic [15:0] e16);
    ready_i = 1'b1; data_i = d; valid_i = 1'b1; last_i = 1'b1;
    step();
    valid_i = 1'b0; last_i = 1'b0;
    step();
    chk({tag, "_v"},   64'(valid_o), 64'(1'b1));
    chk({tag, "_d32"}, 64'(data_o),  64'(e32));
    chk({tag, "_d16"}, 64'(data16),  64'(e16));
    step();
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_cnt"}, 64'(got_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk($sformatf("%s_d%0d", tag, i), 64'(got_d[i]), 64'(exp_d[i]));
      chk($sformatf("%s_l%0d", tag, i), 64'(got_l[i]), 64'(exp_l[i]));
    end
  endtask

  initial begin
    logic [31:0] d4[4];
    int idx;
    int cyc;
    logic acc;

    bias = '0; ready_i = 1'b1;
    bias_lin();
    do_reset();
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_last",  64'(last_o),  64'(0));
    chk("rst_data",  64'(data_o),  64'(0));
    chk("rst_ready", 64'(ready_o), 64'(1));

    // 10 beats of 100, biases 10k, channel wraps after 8.
    for (int i = 0; i < 10; i++) begin
      data_i = 32'd100; valid_i = 1'b1; last_i = 1'b0;
      step();
      if (i == 0) chk("lat_e0_valid", 64'(valid_o), 64'(0));
      if (i == 1) begin
        chk("lat_e1_valid", 64'(valid_o), 64'(1));
        chk("lat_e1_data",  64'(data_o),  64'(100));
      end
    end
    valid_i = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 10; i++) begin
      exp_d.push_back(32'(100 + 10 * (i % 8)));
      exp_l.push_back(1'b0);
    end
    chk_out("seq");

    // ReLU on negative and small positive sums.
    do_reset();
    bias = '0;
    bias[31:0] = 32'd50;
    one_beat("neg", -32'sd100, 32'd0, 16'd0);
    bias[31:0] = 32'd10;
    one_beat("small", -32'sd5, 32'd5, 16'd5);

    // Wide sum without wrap, negative extreme, 16-bit saturation.
    bias[31:0] = 32'h7FFF_FFFF;
    one_beat("max", 32'h7FFF_FFFF, 32'hFFFF_FFFE, 16'hFFFF);
    bias[31:0] = 32'h8000_0000;
    one_beat("min", 32'h8000_0000, 32'd0, 16'd0);
    bias[31:0] = 32'd0;
    one_beat("sat70000", 32'd70000, 32'd70000, 16'hFFFF);
    one_beat("sat65535", 32'd65535, 32'd65535, 16'hFFFF);
    one_beat("sat65536", 32'd65536, 32'd65536, 16'hFFFF);
    one_beat("sat65534", 32'd65534, 32'd65534, 16'hFFFE);

    // Downstream stall for 6 cycles with 4 beats offered.
    do_reset();
    bias_lin();
    d4[0] = 32'd1; d4[1] = 32'd2; d4[2] = 32'd3; d4[3] = 32'd4;
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 30) begin
      ready_i = (cyc >= 6);
      valid_i = 1'b1; last_i = 1'b0; data_i = d4[idx];
      #1;
      acc = valid_i && ready_o;
      step();
      if (acc) idx++;
      if (cyc == 1) begin
        chk("stall_ready", 64'(ready_o), 64'(0));
        chk("stall_accepted", 64'(idx), 64'(2));
      end
      if (cyc >= 2 && cyc <= 5) begin
        chk($sformatf("hold_v%0d", cyc), 64'(valid_o), 64'(1));
        chk($sformatf("hold_d%0d", cyc), 64'(data_o),  64'(1));
      end
      cyc++;
    end
    chk("stall_all_accepted", 64'(idx), 64'(4));
    valid_i = 1'b0;
    repeat (4) step();
    exp_d.push_back(32'd1);  exp_l.push_back(1'b0);
    exp_d.push_back(32'd12); exp_l.push_back(1'b0);
    exp_d.push_back(32'd23); exp_l.push_back(1'b0);
    exp_d.push_back(32'd34); exp_l.push_back(1'b0);
    chk_out("stall");

    // last on the third beat restarts at channel 0.
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = 32'd100; valid_i = 1'b1; last_i = (i == 2);
      step();
    end
    valid_i = 1'b0; last_i = 1'b0;
    repeat (3) step();
    exp_d.push_back(32'd100); exp_l.push_back(1'b0);
    exp_d.push_back(32'd110); exp_l.push_back(1'b0);
    exp_d.push_back(32'd120); exp_l.push_back(1'b1);
    exp_d.push_back(32'd100); exp_l.push_back(1'b0);
    chk_out("last");

    // Reset pulse with two beats in flight.
    do_reset();
    ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      data_i = 32'd1; valid_i = 1'b1; last_i = 1'b0;
      step();
    end
    valid_i = 1'b0;
    rst_i = 1'b1;
    step();
    chk("mrst_valid", 64'(valid_o), 64'(0));
    chk("mrst_data",  64'(data_o),  64'(0));
    chk("mrst_last",  64'(last_o),  64'(0));
    chk("mrst_ready", 64'(ready_o), 64'(1));
    rst_i = 1'b0;
    ready_i = 1'b1;
    step();
    chk("mrst_after_valid", 64'(valid_o), 64'(0));
    got_d.delete(); got_l.delete();
    data_i = 32'd5; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (3) step();
    exp_d.push_back(32'd5); exp_l.push_back(1'b0);
    chk_out("mrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
